// File: rtl/bip2_pkg.sv
// +----------------------------------------------------------------------+
// | bip2_pkg : shared BIP-2 widths, opcode constants and fetch state type |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

package bip2_pkg;

  localparam int ADDR_W = 11;
  localparam int WORD_W = 16;
  localparam int OP_W   = 5;

  localparam logic [OP_W-1:0] OP_HLT = 5'b00000;

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_e;

endpackage

`default_nettype wire

// File: rtl/bip2_instr_counter.sv
// +----------------------------------------------------------------------+
// | bip2_instr_counter : saturating up-counter with enable               |
// | Built only when BIP2_FETCH_INSTR_CNT_EN is defined.  Rev 1.0         |
// +----------------------------------------------------------------------+
`default_nettype none

module bip2_instr_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  // Holds at all-ones rather than wrapping
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_en && (r_count != {WIDTH{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/bip2_fetch.sv
// +----------------------------------------------------------------------+
// | bip2_fetch : BIP-2 instruction fetch (PC, IR, branch, stall, halt)   |
// | Optional issue counter: BIP2_FETCH_INSTR_CNT_EN.  Rev 1.0            |
// +----------------------------------------------------------------------+
`default_nettype none

module bip2_fetch
  import bip2_pkg::*;
(
  input  logic              CLK_i,
  input  logic              RST_i,
  output logic [ADDR_W-1:0] ADDR_im_o,
  input  logic [WORD_W-1:0] DATA_im_i,
  input  logic              STALL_i,
  input  logic              BR_TAKEN_i,
  input  logic [ADDR_W-1:0] BR_TARGET_i,
  input  logic              RESTART_i,
  output logic [WORD_W-1:0] IR_o,
  output logic              IR_VALID_o,
  output logic [ADDR_W-1:0] IR_PC_o,
  output logic              HALTED_o,
  output logic [15:0]       INSTR_CNT_o
);

  fetch_state_e      r_state, w_state_next;
  logic [ADDR_W-1:0] r_pc, w_pc_next;
  logic [WORD_W-1:0] r_ir, w_ir_next;
  logic [ADDR_W-1:0] r_ir_pc, w_ir_pc_next;
  logic              r_ir_valid, w_ir_valid_next;
  logic              w_is_hlt;

  assign w_is_hlt = (DATA_im_i[WORD_W-1 -: OP_W] == OP_HLT);

  always_ff @(posedge CLK_i) begin
    if (RST_i) begin
      r_state    <= RUN;
      r_pc       <= '0;
      r_ir       <= '0;
      r_ir_pc    <= '0;
      r_ir_valid <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_pc       <= w_pc_next;
      r_ir       <= w_ir_next;
      r_ir_pc    <= w_ir_pc_next;
      r_ir_valid <= w_ir_valid_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_pc_next       = r_pc;
    w_ir_next       = r_ir;
    w_ir_pc_next    = r_ir_pc;
    w_ir_valid_next = r_ir_valid;
    case (r_state)
      RUN: begin
        // A redirect discards whatever is on the ROM bus, HLT included
        if (BR_TAKEN_i) begin
          w_pc_next       = BR_TARGET_i;
          w_ir_valid_next = 1'b0;
        end else if (!STALL_i) begin
          w_ir_next       = DATA_im_i;
          w_ir_pc_next    = r_pc;
          w_ir_valid_next = 1'b1;
          if (w_is_hlt) begin
            w_state_next = HALTED;
          end else begin
            w_pc_next = r_pc + 1'b1;
          end
        end
      end
      HALTED: begin
        w_ir_valid_next = 1'b0;
        if (RESTART_i) begin
          w_pc_next    = '0;
          w_state_next = RUN;
        end
      end
      default: begin
        w_state_next = RUN;
      end
    endcase
  end

  assign ADDR_im_o  = r_pc;
  assign IR_o       = r_ir;
  assign IR_PC_o    = r_ir_pc;
  assign IR_VALID_o = r_ir_valid;
  assign HALTED_o   = (r_state == HALTED);

`ifdef BIP2_FETCH_INSTR_CNT_EN
  logic w_cnt_en;
  assign w_cnt_en = r_ir_valid && !STALL_i;

  bip2_instr_counter #(
    .WIDTH (16)
  ) u_instr_counter (
    .clk     (CLK_i),
    .rst     (RST_i),
    .i_en    (w_cnt_en),
    .o_count (INSTR_CNT_o)
  );
`else
  assign INSTR_CNT_o = '0;
`endif

endmodule

`default_nettype wire
